loopback_engine: RTL and testbench

- Parametrised successor to the single-mode DDR loopback datapath.
- Sits between the memory controller's stream FIFO, buffer-read FIFO and output buffer.
- Processes a configured number of stream words in one of three modes: PASS, BIAS and DROP.
- In BIAS mode it adds a per-lane bias fetched from the buffer-read port and re-fetched every N words. It counts words and pulses done when the job completes.

---
 rtl/loopback_engine.sv | 154 +++++++++++++++
 tb/tb_loopback_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_engine.sv
// Loopback engine: moves a configured number of stream words to the output buffer in PASS/BIAS/DROP mode.
// Define LOOPBACK_ENGINE_SAT_EN for signed-saturating BIAS addition (the default wraps).
module loopback_engine #(
  parameter int NUM_PE     = 4,
  parameter int OP_WIDTH   = 16,
  parameter int BUF_DATA_W = 64,
  parameter int CNT_W      = 20,
  parameter int REUSE_W    = 8,
  parameter int STREAM_W   = NUM_PE * OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_W-1:0]      cfg_num_words,
  input  logic [REUSE_W-1:0]    cfg_bias_reuse,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      word_count,
  output logic                  stream_read_req,
  input  logic [STREAM_W-1:0]   stream_read_data,
  input  logic                  stream_read_ready,
  output logic                  buffer_read_req,
  input  logic [BUF_DATA_W-1:0] buffer_read_data,
  input  logic                  buffer_read_ready,
  output logic                  stream_write_req,
  output logic [STREAM_W-1:0]   stream_write_data,
  input  logic                  stream_write_ready
);

  typedef enum logic [1:0] {IDLE, LOAD_BIAS, RUN, DONE} state_t;
  typedef enum logic [1:0] {MODE_PASS, MODE_BIAS, MODE_DROP, MODE_RSVD} mode_t;

  state_t               state, state_nxt;
  mode_t                mode_r;
  logic [CNT_W-1:0]     num_words_r;
  logic [REUSE_W-1:0]   reuse_r;
  logic [REUSE_W-1:0]   reuse_cnt;
  logic [OP_WIDTH-1:0]  bias;
  logic                 out_valid;
  logic [STREAM_W-1:0]  out_data;
  logic [STREAM_W-1:0]  next_data;

  logic cfg_fire, stream_pop, bias_pop, push, last_word, reuse_end;
  logic unused_buf_bits;

  // Only the low lane of a buffer word carries the bias.
  assign unused_buf_bits = ^buffer_read_data;

  assign cfg_fire   = cfg_valid && (state == IDLE);
  assign bias_pop   = (state == LOAD_BIAS) && buffer_read_ready;
  assign stream_pop = (state == RUN) && stream_read_ready &&
                      (!out_valid || stream_write_ready || (mode_r == MODE_DROP));
  assign push       = out_valid && stream_write_ready;
  assign last_word  = (word_count + CNT_W'(1)) == num_words_r;
  assign reuse_end  = (reuse_cnt + REUSE_W'(1)) == reuse_r;

  function automatic logic [OP_WIDTH-1:0] add_lane(input logic [OP_WIDTH-1:0] a,
                                                    input logic [OP_WIDTH-1:0] b);
`ifdef LOOPBACK_ENGINE_SAT_EN
    logic [OP_WIDTH:0] sum;
    sum = {a[OP_WIDTH-1], a} + {b[OP_WIDTH-1], b};
    if (sum[OP_WIDTH] != sum[OP_WIDTH-1])
      add_lane = sum[OP_WIDTH] ? {1'b1, {(OP_WIDTH-1){1'b0}}} : {1'b0, {(OP_WIDTH-1){1'b1}}};
    else
      add_lane = sum[OP_WIDTH-1:0];
`else
    add_lane = a + b;
`endif
  endfunction

  always_comb begin
    next_data = stream_read_data;
    if (mode_r == MODE_BIAS) begin
      for (int unsigned i = 0; i < NUM_PE; i++)
        next_data[i*OP_WIDTH +: OP_WIDTH] = add_lane(stream_read_data[i*OP_WIDTH +: OP_WIDTH], bias);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_num_words == '0)                 state_nxt = DONE;
          else if (mode_t'(cfg_mode) == MODE_BIAS) state_nxt = LOAD_BIAS;
          else                                     state_nxt = RUN;
        end
      end
      LOAD_BIAS: if (buffer_read_ready) state_nxt = RUN;
      RUN: begin
        // Job end takes priority over a due bias refetch.
        if (stream_pop) begin
          if (last_word)                              state_nxt = DONE;
          else if ((mode_r == MODE_BIAS) && reuse_end) state_nxt = LOAD_BIAS;
        end
      end
      DONE: if (!out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready         = (state == IDLE);
    busy              = (state != IDLE);
    done              = (state == DONE) && !out_valid;
    stream_read_req   = stream_pop;
    buffer_read_req   = bias_pop;
    stream_write_req  = push;
    stream_write_data = out_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_r      <= MODE_PASS;
      num_words_r <= '0;
      reuse_r     <= REUSE_W'(1);
      reuse_cnt   <= '0;
      word_count  <= '0;
      bias        <= '0;
    end else if (cfg_fire) begin
      mode_r      <= mode_t'(cfg_mode);
      num_words_r <= cfg_num_words;
      reuse_r     <= (cfg_bias_reuse == '0) ? REUSE_W'(1) : cfg_bias_reuse;
      reuse_cnt   <= '0;
      word_count  <= '0;
    end else if (bias_pop) begin
      bias      <= buffer_read_data[OP_WIDTH-1:0];
      reuse_cnt <= '0;
    end else if (stream_pop) begin
      word_count <= word_count + CNT_W'(1);
      if (mode_r == MODE_BIAS) reuse_cnt <= reuse_cnt + REUSE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (stream_pop && (mode_r != MODE_DROP)) begin
      out_valid <= 1'b1;
      out_data  <= next_data;
    end else if (push) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_loopback_engine.sv
// Directed self-checking bench for loopback_engine with show-ahead FIFO models on both read ports.
// Expected BIAS overflow results follow LOOPBACK_ENGINE_SAT_EN when it is defined.
module tb_loopback_engine;
  localparam int NUM_PE     = 4;
  localparam int OP_WIDTH   = 16;
  localparam int BUF_DATA_W = 64;
  localparam int CNT_W      = 20;
  localparam int REUSE_W    = 8;
  localparam int STREAM_W   = NUM_PE * OP_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [1:0]            cfg_mode = 2'd0;
  logic [CNT_W-1:0]      cfg_num_words = '0;
  logic [REUSE_W-1:0]    cfg_bias_reuse = '0;
  logic                  busy, done;
  logic [CNT_W-1:0]      word_count;
  logic                  stream_read_req, stream_read_ready;
  logic [STREAM_W-1:0]   stream_read_data;
  logic                  buffer_read_req, buffer_read_ready;
  logic [BUF_DATA_W-1:0] buffer_read_data;
  logic                  stream_write_req;
  logic [STREAM_W-1:0]   stream_write_data;
  logic                  stream_write_ready = 1'b1;

  loopback_engine #(
    .NUM_PE(NUM_PE), .OP_WIDTH(OP_WIDTH), .BUF_DATA_W(BUF_DATA_W),
    .CNT_W(CNT_W), .REUSE_W(REUSE_W), .STREAM_W(STREAM_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_num_words(cfg_num_words), .cfg_bias_reuse(cfg_bias_reuse),
    .busy(busy), .done(done), .word_count(word_count),
    .stream_read_req(stream_read_req), .stream_read_data(stream_read_data),
    .stream_read_ready(stream_read_ready),
    .buffer_read_req(buffer_read_req), .buffer_read_data(buffer_read_data),
    .buffer_read_ready(buffer_read_ready),
    .stream_write_req(stream_write_req), .stream_write_data(stream_write_data),
    .stream_write_ready(stream_write_ready)
  );

  always #5 clk = ~clk;

  logic [STREAM_W-1:0]   s_mem [64];
  logic [BUF_DATA_W-1:0] b_mem [64];
  logic [STREAM_W-1:0]   w_mem [64];
  int s_wr = 0, s_rd = 0, b_wr = 0, b_rd = 0;
  int w_cnt = 0, s_pops = 0, b_pops = 0, done_cnt = 0, viol = 0;
  int cyc = 0, first_pop = -1, first_push = -1, last_push = -1, done_cyc = -1;
  bit pend_s = 0, pend_b = 0;
  int total = 0, bad = 0;

  assign stream_read_ready = (s_rd < s_wr);
  assign stream_read_data  = s_mem[s_rd[5:0]];
  assign buffer_read_ready = (b_rd < b_wr);
  assign buffer_read_data  = b_mem[b_rd[5:0]];

  // Requests are sampled mid-cycle; the FIFO head advances after the edge that consumed it.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pend_s) s_rd = s_rd + 1;
    if (pend_b) b_rd = b_rd + 1;
    pend_s = 0;
    pend_b = 0;
    #1;
    if (stream_read_req === 1'b1) begin
      pend_s = 1; s_pops++;
      if (first_pop < 0) first_pop = cyc;
      if (!stream_read_ready) viol++;
    end
    if (buffer_read_req === 1'b1) begin
      pend_b = 1; b_pops++;
      if (!buffer_read_ready) viol++;
    end
    if (stream_write_req === 1'b1) begin
      if (w_cnt < 64) w_mem[w_cnt] = stream_write_data;
      w_cnt++;
      if (first_push < 0) first_push = cyc;
      last_push = cyc;
      if (!stream_write_ready) viol++;
    end
    if (done === 1'b1) begin
      done_cnt++; done_cyc = cyc;
    end
  end

  task automatic clear_fifos();
    @(negedge clk); #2;
    s_wr = 0; s_rd = 0; b_wr = 0; b_rd = 0; pend_s = 0; pend_b = 0;
    w_cnt = 0; s_pops = 0; b_pops = 0; done_cnt = 0;
    first_pop = -1; first_push = -1; last_push = -1; done_cyc = -1;
  endtask

  task automatic start_job(input logic [1:0] m, input int n, input int r, output int sc);
    @(negedge clk);
    cfg_mode = m; cfg_num_words = CNT_W'(n); cfg_bias_reuse = REUSE_W'(r); cfg_valid = 1'b1;
    #2 sc = cyc;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    to = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (done_cnt > 0) begin to = 0; break; end
    end
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
    total++; if (stream_write_req !== 1'b0) begin bad++; $display("FAIL rst_wreq: got %b want 0", stream_write_req); end
    reset = 1'b1;
    @(negedge clk); #2;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (word_count !== '0) begin bad++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
    total++; if (stream_read_req !== 1'b0 || buffer_read_req !== 1'b0) begin
      bad++; $display("FAIL rst_rreq: got %b%b want 00", stream_read_req, buffer_read_req); end
  endtask

  task automatic test_pass();
    logic [63:0] vec [8] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_0000,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_7FFF_0001_FFFE, 64'h1111_2222_3333_4444,
                             64'hA5A5_5A5A_C3C3_3C3C, 64'h0F0F_F0F0_00FF_FF00};
    int sc; bit to;
    clear_fifos();
    for (int i = 0; i < 8; i++) s_mem[i] = vec[i];
    s_wr = 8;
    start_job(2'd0, 8, 1, sc);
    wait_done(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL pass_timeout: got %b want 0", to); end
    total++; if (w_cnt !== 8) begin bad++; $display("FAIL pass_pushes: got %0d want 8", w_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++; if (w_mem[i] !== vec[i]) begin bad++; $display("FAIL pass_data[%0d]: got %h want %h", i, w_mem[i], vec[i]); end
    end
    total++; if (first_push !== first_pop + 1) begin bad++; $display("FAIL pass_latency: got %0d want %0d", first_push, first_pop + 1); end
    total++; if (last_push - first_push !== 7) begin bad++; $display("FAIL pass_back_to_back: got span %0d want 7", last_push - first_push); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL pass_done_pulses: got %0d want 1", done_cnt); end
    total++; if (word_count !== CNT_W'(8)) begin bad++; $display("FAIL pass_word_count: got %0d want 8", word_count); end
  endtask

  task automatic test_bias();
    logic [63:0] exp_w [6] = '{64'h0006_0006_0006_0006, 64'h0006_0006_0006_0006, 64'h0015_0015_0015_0015,
                               64'h0015_0015_0015_0015, 64'h0105_0105_0105_0105, 64'h0105_0105_0105_0105};
    int sc; bit to;
    clear_fifos();
    for (int i = 0; i < 6; i++) s_mem[i] = 64'h0005_0005_0005_0005;
    s_wr = 6;
    b_mem[0] = 64'hDEAD_BEEF_0000_0001; b_mem[1] = 64'h0000_0000_0000_0010;
    b_mem[2] = 64'hFFFF_0000_0000_0100; b_mem[3] = 64'h0000_0000_0000_7777;
    b_wr = 4;
    start_job(2'd1, 6, 2, sc);
    wait_done(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL bias_timeout: got %b want 0", to); end
    total++; if (w_cnt !== 6) begin bad++; $display("FAIL bias_pushes: got %0d want 6", w_cnt); end
    for (int i = 0; i < 6; i++) begin
      total++; if (w_mem[i] !== exp_w[i]) begin bad++; $display("FAIL bias_data[%0d]: got %h want %h", i, w_mem[i], exp_w[i]); end
    end
    total++; if (b_pops !== 3) begin bad++; $display("FAIL bias_buffer_pops: got %0d want 3", b_pops); end
    total++; if (word_count !== CNT_W'(6)) begin bad++; $display("FAIL bias_word_count: got %0d want 6", word_count); end
  endtask

  task automatic test_bias_overflow();
`ifdef LOOPBACK_ENGINE_SAT_EN
    logic [63:0] exp_w [2] = '{64'h7FFF_0004_7FFF_FFFF, 64'h8000_0004_8000_FFFF};
`else
    logic [63:0] exp_w [2] = '{64'h8000_0004_8000_FFFF, 64'h7FFF_0004_8000_FFFF};
`endif
    int sc; bit to;
    clear_fifos();
    s_mem[0] = 64'h7FFF_0003_7FFF_FFFE; s_mem[1] = 64'h8000_0005_8001_0000; s_wr = 2;
    b_mem[0] = 64'h0000_0000_0000_0001; b_mem[1] = 64'h1234_5678_9ABC_FFFF; b_wr = 2;
    start_job(2'd1, 2, 0, sc);
    wait_done(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL ovf_timeout: got %b want 0", to); end
    for (int i = 0; i < 2; i++) begin
      total++; if (w_mem[i] !== exp_w[i]) begin bad++; $display("FAIL ovf_data[%0d]: got %h want %h", i, w_mem[i], exp_w[i]); end
    end
    total++; if (b_pops !== 2) begin bad++; $display("FAIL ovf_buffer_pops: got %0d want 2", b_pops); end
  endtask

  task automatic test_backpressure();
    logic [63:0] vec [4] = '{64'h1000_2000_3000_4000, 64'h5555_6666_7777_8888,
                             64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001};
    int sc, pops0, w0; bit to;
    clear_fifos();
    for (int i = 0; i < 4; i++) s_mem[i] = vec[i];
    s_wr = 4;
    start_job(2'd0, 4, 1, sc);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (w_cnt >= 1) break;
    end
    @(negedge clk);
    stream_write_ready = 1'b0;
    #2 pops0 = s_pops; w0 = w_cnt;
    repeat (4) @(negedge clk);
    #2;
    total++; if (s_pops !== pops0) begin bad++; $display("FAIL bp_no_pop_when_full: got %0d want %0d", s_pops, pops0); end
    total++; if (w0 !== 1 || w_cnt !== 1) begin bad++; $display("FAIL bp_stalled_pushes: got %0d/%0d want 1/1", w0, w_cnt); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL bp_early_done: got %0d want 0", done_cnt); end
    @(negedge clk);
    stream_write_ready = 1'b1;
    wait_done(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout: got %b want 0", to); end
    total++; if (w_cnt !== 4) begin bad++; $display("FAIL bp_pushes: got %0d want 4", w_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (w_mem[i] !== vec[i]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, w_mem[i], vec[i]); end
    end
    total++; if (!(done_cyc > last_push)) begin bad++; $display("FAIL bp_done_after_push: got done %0d push %0d want done later", done_cyc, last_push); end
  endtask

  task automatic test_drop();
    int sc; bit to;
    clear_fifos();
    for (int i = 0; i < 10; i++) s_mem[i] = 64'h0BAD_0BAD_0BAD_0000 + 64'(i);
    s_wr = 10;
    start_job(2'd2, 10, 1, sc);
    wait_done(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL drop_timeout: got %b want 0", to); end
    total++; if (s_pops !== 10) begin bad++; $display("FAIL drop_pops: got %0d want 10", s_pops); end
    total++; if (w_cnt !== 0) begin bad++; $display("FAIL drop_writes: got %0d want 0", w_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL drop_done_pulses: got %0d want 1", done_cnt); end
    total++; if (word_count !== CNT_W'(10)) begin bad++; $display("FAIL drop_word_count: got %0d want 10", word_count); end
    clear_fifos();
    s_mem[0] = 64'h1; s_wr = 1;
    start_job(2'd0, 0, 1, sc);
    wait_done(to);
    total++; if (done_cyc !== sc + 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, sc + 1); end
    total++; if (s_pops !== 0) begin bad++; $display("FAIL zero_pops: got %0d want 0", s_pops); end
    total++; if (word_count !== '0) begin bad++; $display("FAIL zero_word_count: got %0d want 0", word_count); end
  endtask

  task automatic test_reset_mid_job();
    logic [63:0] vec [3] = '{64'hCAFE_0001_0002_0003, 64'h0004_0005_0006_0007, 64'h7FFF_8000_FFFF_0000};
    int sc; bit to;
    clear_fifos();
    for (int i = 0; i < 10; i++) s_mem[i] = 64'h0001_0001_0001_0001;
    s_wr = 10;
    for (int i = 0; i < 4; i++) b_mem[i] = 64'h2;
    b_wr = 4;
    start_job(2'd1, 10, 3, sc);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (stream_write_req !== 1'b0) begin bad++; $display("FAIL mid_rst_wreq: got %b want 0", stream_write_req); end
    total++; if (word_count !== '0) begin bad++; $display("FAIL mid_rst_word_count: got %0d want 0", word_count); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_cfg_ready: got %b want 1", cfg_ready); end
    reset = 1'b1;
    clear_fifos();
    for (int i = 0; i < 3; i++) s_mem[i] = vec[i];
    s_wr = 3;
    start_job(2'd3, 3, 1, sc);
    wait_done(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL post_rst_timeout: got %b want 0", to); end
    total++; if (w_cnt !== 3) begin bad++; $display("FAIL post_rst_pushes: got %0d want 3", w_cnt); end
    for (int i = 0; i < 3; i++) begin
      total++; if (w_mem[i] !== vec[i]) begin bad++; $display("FAIL post_rst_data[%0d]: got %h want %h", i, w_mem[i], vec[i]); end
    end
    total++; if (word_count !== CNT_W'(3)) begin bad++; $display("FAIL post_rst_word_count: got %0d want 3", word_count); end
  endtask

  task automatic test_protocol();
    total++; if (viol !== 0) begin bad++; $display("FAIL req_without_ready: got %0d want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_bias();
    test_bias_overflow();
    test_backpressure();
    test_drop();
    test_reset_mid_job();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
